// File: rtl/mem_req_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_common (package)
// Description : Shared memory-request types: requester identity, tag type,
//               and request/response bundles, used by the request arbiter
//               and its tag tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_common;

    localparam int MEM_PADDR_W  = 32;
    localparam int MEM_DATA_W   = 32;
    localparam int MEM_NUM_TAGS = 4;
    localparam int MEM_TAG_W    = $clog2(MEM_NUM_TAGS);

    // Identity of the requester that owns an outstanding tag.
    typedef enum logic {
        SRC_FE = 1'b0,
        SRC_LD = 1'b1
    } t_mem_src;

    typedef logic [MEM_TAG_W-1:0] t_mem_tag;

    typedef struct packed {
        logic                   valid;
        logic [MEM_PADDR_W-1:0] addr;
        t_mem_tag               tag;
    } t_mem_req;

    typedef struct packed {
        logic                  valid;
        t_mem_tag              tag;
        logic [MEM_DATA_W-1:0] data;
    } t_mem_rsp;

endpackage : mem_common
`default_nettype wire

// File: rtl/mem_req_arb_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module      : mem_tag_tracker
// Description : Outstanding-request tag table. Each tag holds a valid bit,
//               owning requester and a stale mark. Provides lowest-index
//               free tag, allocate, free, FE flush-marking, response lookup
//               and a registered count of allocated tags.
// Ports       : clk/reset        - clock, synchronous active-high reset
//               alloc_en/src     - allocate free_idx to src at the edge
//               free_en/rsp_tag  - release rsp_tag at the edge
//               flush            - mark every live FE tag stale
//               free_avail/idx   - a free tag exists / lowest free index
//               lookup_*         - table contents for rsp_tag
//               outstanding_cnt  - number of allocated tags
// Revision    : 1.0 - initial release
// ============================================================================
module mem_tag_tracker
    import mem_common::*;
#(
    parameter int NUM_TAGS = 4,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_en,
    input  t_mem_src         alloc_src,
    input  logic             free_en,
    input  logic [TAG_W-1:0] rsp_tag,
    input  logic             flush,
    output logic             free_avail,
    output logic [TAG_W-1:0] free_idx,
    output logic             lookup_vld,
    output t_mem_src         lookup_src,
    output logic             lookup_stale,
    output logic [TAG_W:0]   outstanding_cnt
);

    logic [NUM_TAGS-1:0] r_vld;
    logic [NUM_TAGS-1:0] r_stale;
    t_mem_src            r_src [NUM_TAGS];
    logic [TAG_W:0]      r_cnt;

    logic [NUM_TAGS-1:0] w_vld_nxt;
    logic [NUM_TAGS-1:0] w_stale_nxt;
    t_mem_src            w_src_nxt [NUM_TAGS];
    logic [TAG_W:0]      w_cnt_nxt;
    logic [TAG_W-1:0]    w_free_idx;

    // Lowest-index free tag: scanning downward leaves the smallest hit.
    always_comb begin
        w_free_idx = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!r_vld[i]) begin
                w_free_idx = TAG_W'(i);
            end
        end
    end

    assign free_avail   = ~(&r_vld);
    assign free_idx     = w_free_idx;
    assign lookup_vld   = r_vld[rsp_tag];
    assign lookup_src   = r_src[rsp_tag];
    assign lookup_stale = r_stale[rsp_tag];

    // Flush marks, then free, then allocate. The allocated tag is free in the
    // current table, so it never collides with the tag being released.
    always_comb begin
        w_vld_nxt   = r_vld;
        w_stale_nxt = r_stale;
        for (int i = 0; i < NUM_TAGS; i++) begin
            w_src_nxt[i] = r_src[i];
            if (flush && r_vld[i] && (r_src[i] == SRC_FE)) begin
                w_stale_nxt[i] = 1'b1;
            end
        end
        if (free_en) begin
            w_vld_nxt[rsp_tag] = 1'b0;
        end
        if (alloc_en) begin
            w_vld_nxt[w_free_idx]   = 1'b1;
            w_stale_nxt[w_free_idx] = 1'b0;
            w_src_nxt[w_free_idx]   = alloc_src;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + (TAG_W+1)'(w_vld_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld   <= '0;
            r_stale <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_src[i] <= SRC_FE;
            end
        end else begin
            r_vld   <= w_vld_nxt;
            r_stale <= w_stale_nxt;
            r_cnt   <= w_cnt_nxt;
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_src[i] <= w_src_nxt[i];
            end
        end
    end

    assign outstanding_cnt = r_cnt;

endmodule : mem_tag_tracker
`default_nettype wire

// File: rtl/mem_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arb
// Description : Shares one memory request port between instruction fetch
//               (FE) and data-miss (LD) requesters with round-robin
//               arbitration, tags each request from a small pool, and routes
//               tagged responses back to their owner. FE responses made
//               stale by a mispredict flush are dropped.
// Ports       : fe_req_* / ld_req_*  - requester valid/addr in, grant out
//               fe_flush             - discard in-flight FE requests
//               mem_req_*            - downstream request (valid/addr/tag/ready)
//               mem_rsp_*            - downstream tagged response
//               fe_rsp_* / ld_rsp_*  - registered routed responses
//               outstanding_cnt      - number of allocated tags
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arb
    import mem_common::*;
#(
    parameter int PADDR_W  = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_TAGS = 4,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fe_req_valid,
    input  logic [PADDR_W-1:0] fe_req_addr,
    output logic               fe_req_gnt,
    input  logic               ld_req_valid,
    input  logic [PADDR_W-1:0] ld_req_addr,
    output logic               ld_req_gnt,
    input  logic               fe_flush,
    output logic               mem_req_valid,
    output logic [PADDR_W-1:0] mem_req_addr,
    output logic [TAG_W-1:0]   mem_req_tag,
    input  logic               mem_req_ready,
    input  logic               mem_rsp_valid,
    input  logic [TAG_W-1:0]   mem_rsp_tag,
    input  logic [DATA_W-1:0]  mem_rsp_data,
    output logic               fe_rsp_valid,
    output logic [DATA_W-1:0]  fe_rsp_data,
    output logic               ld_rsp_valid,
    output logic [DATA_W-1:0]  ld_rsp_data,
    output logic [TAG_W:0]     outstanding_cnt
);

    t_mem_src          r_rr_last;
    logic              r_fe_rsp_valid;
    logic              r_ld_rsp_valid;
    logic [DATA_W-1:0] r_fe_rsp_data;
    logic [DATA_W-1:0] r_ld_rsp_data;

    logic              w_fe_elig;
    logic              w_ld_elig;
    logic              w_sel_ld;
    t_mem_src          w_sel_src;
    logic              w_req_valid;
    logic              w_grant;
    logic              w_free_avail;
    logic [TAG_W-1:0]  w_free_idx;
    logic              w_lookup_vld;
    t_mem_src          w_lookup_src;
    logic              w_lookup_stale;
    logic              w_rsp_hit;
    logic              w_fe_rsp;
    logic              w_ld_rsp;

    // A flush in flight makes any FE fetch pointless, so FE sits out.
    assign w_fe_elig = fe_req_valid & ~fe_flush;
    assign w_ld_elig = ld_req_valid;

    // LD wins when alone, or on a conflict when FE was granted last.
    assign w_sel_ld  = w_ld_elig & (~w_fe_elig | (r_rr_last == SRC_FE));
    assign w_sel_src = w_sel_ld ? SRC_LD : SRC_FE;

    assign w_req_valid = (w_fe_elig | w_ld_elig) & w_free_avail & ~reset;
    assign w_grant     = w_req_valid & mem_req_ready;

    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = w_req_valid ? (w_sel_ld ? ld_req_addr : fe_req_addr) : '0;
    assign mem_req_tag   = w_req_valid ? w_free_idx : '0;
    assign fe_req_gnt    = w_grant & ~w_sel_ld;
    assign ld_req_gnt    = w_grant &  w_sel_ld;

    // Responses to unallocated tags are ignored. A flush arriving with an FE
    // response drops it, just as if the tag had already been marked stale.
    assign w_rsp_hit = mem_rsp_valid & w_lookup_vld;
    assign w_fe_rsp  = w_rsp_hit & (w_lookup_src == SRC_FE) & ~w_lookup_stale & ~fe_flush;
    assign w_ld_rsp  = w_rsp_hit & (w_lookup_src == SRC_LD);

    mem_tag_tracker #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_tag_tracker (
        .clk             (clk),
        .reset           (reset),
        .alloc_en        (w_grant),
        .alloc_src       (w_sel_src),
        .free_en         (w_rsp_hit),
        .rsp_tag         (mem_rsp_tag),
        .flush           (fe_flush),
        .free_avail      (w_free_avail),
        .free_idx        (w_free_idx),
        .lookup_vld      (w_lookup_vld),
        .lookup_src      (w_lookup_src),
        .lookup_stale    (w_lookup_stale),
        .outstanding_cnt (outstanding_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_last      <= SRC_LD;
            r_fe_rsp_valid <= 1'b0;
            r_ld_rsp_valid <= 1'b0;
            r_fe_rsp_data  <= '0;
            r_ld_rsp_data  <= '0;
        end else begin
            if (w_grant) begin
                r_rr_last <= w_sel_src;
            end
            r_fe_rsp_valid <= w_fe_rsp;
            r_ld_rsp_valid <= w_ld_rsp;
            // Data registers only load on a delivered response and hold otherwise.
            if (w_fe_rsp) begin
                r_fe_rsp_data <= mem_rsp_data;
            end
            if (w_ld_rsp) begin
                r_ld_rsp_data <= mem_rsp_data;
            end
        end
    end

    assign fe_rsp_valid = r_fe_rsp_valid;
    assign fe_rsp_data  = r_fe_rsp_data;
    assign ld_rsp_valid = r_ld_rsp_valid;
    assign ld_rsp_data  = r_ld_rsp_data;

`ifdef ASSERT
    always @(posedge clk) begin
        if (!reset && mem_rsp_valid) begin
            assert (w_lookup_vld) else $error("response for unallocated tag %0d", mem_rsp_tag);
        end
    end
`endif

endmodule : mem_req_arb
`default_nettype wire

// File: tb/tb_mem_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_arb
// Description : Directed self-checking bench for mem_req_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arb;

    localparam int PADDR_W  = 32;
    localparam int DATA_W   = 32;
    localparam int NUM_TAGS = 4;
    localparam int TAG_W    = 2;

    logic               clk;
    logic               reset;
    logic               fe_req_valid;
    logic [PADDR_W-1:0] fe_req_addr;
    logic               fe_req_gnt;
    logic               ld_req_valid;
    logic [PADDR_W-1:0] ld_req_addr;
    logic               ld_req_gnt;
    logic               fe_flush;
    logic               mem_req_valid;
    logic [PADDR_W-1:0] mem_req_addr;
    logic [TAG_W-1:0]   mem_req_tag;
    logic               mem_req_ready;
    logic               mem_rsp_valid;
    logic [TAG_W-1:0]   mem_rsp_tag;
    logic [DATA_W-1:0]  mem_rsp_data;
    logic               fe_rsp_valid;
    logic [DATA_W-1:0]  fe_rsp_data;
    logic               ld_rsp_valid;
    logic [DATA_W-1:0]  ld_rsp_data;
    logic [TAG_W:0]     outstanding_cnt;

    int n_vec;
    int n_err;

    mem_req_arb #(
        .PADDR_W  (PADDR_W),
        .DATA_W   (DATA_W),
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fe_req_valid    (fe_req_valid),
        .fe_req_addr     (fe_req_addr),
        .fe_req_gnt      (fe_req_gnt),
        .ld_req_valid    (ld_req_valid),
        .ld_req_addr     (ld_req_addr),
        .ld_req_gnt      (ld_req_gnt),
        .fe_flush        (fe_flush),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_req_tag     (mem_req_tag),
        .mem_req_ready   (mem_req_ready),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_tag     (mem_rsp_tag),
        .mem_rsp_data    (mem_rsp_data),
        .fe_rsp_valid    (fe_rsp_valid),
        .fe_rsp_data     (fe_rsp_data),
        .ld_rsp_valid    (ld_rsp_valid),
        .ld_rsp_data     (ld_rsp_data),
        .outstanding_cnt (outstanding_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fe_req_valid  = 1'b0;
        fe_req_addr   = '0;
        ld_req_valid  = 1'b0;
        ld_req_addr   = '0;
        fe_flush      = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_tag   = '0;
        mem_rsp_data  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();

        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_cnt", outstanding_cnt, 0);
        chk("rst_fe_rsp_valid", fe_rsp_valid, 0);
        chk("rst_ld_rsp_valid", ld_rsp_valid, 0);
        chk("rst_fe_rsp_data", fe_rsp_data, 0);
        reset = 1'b0;

        // ---- Single FE request and response ----
        fe_req_valid  = 1'b1;
        fe_req_addr   = 32'h100;
        mem_req_ready = 1'b1;
        #1;
        chk("t1_fe_gnt", fe_req_gnt, 1);
        chk("t1_ld_gnt", ld_req_gnt, 0);
        chk("t1_req_valid", mem_req_valid, 1);
        chk("t1_req_addr", mem_req_addr, 32'h100);
        chk("t1_req_tag", mem_req_tag, 0);
        tick();
        fe_req_valid = 1'b0;
        chk("t1_cnt_after_gnt", outstanding_cnt, 1);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 2'd0;
        mem_rsp_data  = 32'hDEADBEEF;
        #1;
        chk("t1_rsp_not_early", fe_rsp_valid, 0);
        tick();
        mem_rsp_valid = 1'b0;
        chk("t1_fe_rsp_valid", fe_rsp_valid, 1);
        chk("t1_fe_rsp_data", fe_rsp_data, 32'hDEADBEEF);
        chk("t1_ld_rsp_valid", ld_rsp_valid, 0);
        chk("t1_cnt_after_rsp", outstanding_cnt, 0);
        tick();
        chk("t1_fe_rsp_drop", fe_rsp_valid, 0);
        chk("t1_fe_rsp_hold", fe_rsp_data, 32'hDEADBEEF);

        // ---- Round-robin fill; reset must restore FE-first priority ----
        do_reset();
        fe_req_valid  = 1'b1;
        fe_req_addr   = 32'hA00;
        ld_req_valid  = 1'b1;
        ld_req_addr   = 32'hB00;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t2_fe_gnt_%0d", i), fe_req_gnt, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("t2_ld_gnt_%0d", i), ld_req_gnt, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("t2_tag_%0d", i), mem_req_tag, i);
            chk($sformatf("t2_addr_%0d", i), mem_req_addr, (i % 2 == 0) ? 32'hA00 : 32'hB00);
            tick();
        end
        #1;
        chk("t2_full_valid", mem_req_valid, 0);
        chk("t2_full_fe_gnt", fe_req_gnt, 0);
        chk("t2_full_ld_gnt", ld_req_gnt, 0);
        chk("t2_full_cnt", outstanding_cnt, 4);

        // ---- Freed tag becomes allocatable only on the next cycle ----
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 2'd2;
        mem_rsp_data  = 32'h22;
        #1;
        chk("t3_same_cycle_valid", mem_req_valid, 0);
        chk("t3_same_cycle_gnt", fe_req_gnt, 0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("t3_fe_rsp_valid", fe_rsp_valid, 1);
        chk("t3_fe_rsp_data", fe_rsp_data, 32'h22);
        chk("t3_reuse_valid", mem_req_valid, 1);
        chk("t3_reuse_tag", mem_req_tag, 2);
        chk("t3_reuse_fe_gnt", fe_req_gnt, 1);
        chk("t3_reuse_ld_gnt", ld_req_gnt, 0);
        chk("t3_cnt_mid", outstanding_cnt, 3);
        tick();
        chk("t3_cnt_refull", outstanding_cnt, 4);
        fe_req_valid  = 1'b0;
        ld_req_valid  = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 2'd1;
        mem_rsp_data  = 32'h11;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t3_ld_rsp_valid", ld_rsp_valid, 1);
        chk("t3_ld_rsp_data", ld_rsp_data, 32'h11);
        chk("t3_ld_rsp_no_fe", fe_rsp_valid, 0);
        chk("t3_cnt_drain", outstanding_cnt, 3);

        // ---- Flush makes in-flight FE responses stale ----
        do_reset();
        chk("t4_cnt_after_reset", outstanding_cnt, 0);
        fe_req_valid  = 1'b1;
        fe_req_addr   = 32'h200;
        mem_req_ready = 1'b1;
        tick();
        tick();
        chk("t4_cnt_two_fe", outstanding_cnt, 2);
        fe_flush = 1'b1;
        #1;
        chk("t4_flush_blocks_gnt", fe_req_gnt, 0);
        chk("t4_flush_blocks_valid", mem_req_valid, 0);
        tick();
        fe_flush     = 1'b0;
        fe_req_valid = 1'b0;
        for (int t = 0; t < 2; t++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_tag   = TAG_W'(t);
            mem_rsp_data  = 32'h5000 + t;
            tick();
            mem_rsp_valid = 1'b0;
            chk($sformatf("t4_stale_drop_%0d", t), fe_rsp_valid, 0);
        end
        chk("t4_cnt_drained", outstanding_cnt, 0);
        chk("t4_data_hold", fe_rsp_data, 0);
        fe_req_valid = 1'b1;
        fe_req_addr  = 32'h300;
        #1;
        chk("t4_new_tag", mem_req_tag, 0);
        tick();
        fe_req_valid  = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 2'd0;
        mem_rsp_data  = 32'h12345678;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t4_new_rsp_valid", fe_rsp_valid, 1);
        chk("t4_new_rsp_data", fe_rsp_data, 32'h12345678);

        // ---- Flush colliding with FE request and FE response ----
        do_reset();
        fe_req_valid  = 1'b1;
        fe_req_addr   = 32'h400;
        mem_req_ready = 1'b1;
        tick();
        fe_req_addr   = 32'h440;
        fe_flush      = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 2'd0;
        mem_rsp_data  = 32'h55;
        #1;
        chk("t5_flush_fe_gnt", fe_req_gnt, 0);
        tick();
        fe_flush      = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        chk("t5_no_fe_rsp", fe_rsp_valid, 0);
        chk("t5_cnt_freed", outstanding_cnt, 0);
        chk("t5_fe_gnt_after", fe_req_gnt, 1);
        chk("t5_tag_after", mem_req_tag, 0);
        chk("t5_addr_after", mem_req_addr, 32'h440);
        tick();
        fe_req_valid = 1'b0;
        chk("t5_cnt_regrant", outstanding_cnt, 1);

        // ---- Backpressure holds the LD request without allocating ----
        do_reset();
        ld_req_valid = 1'b1;
        ld_req_addr  = 32'hC0C0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("t6_bp_gnt_%0d", c), ld_req_gnt, 0);
            chk($sformatf("t6_bp_valid_%0d", c), mem_req_valid, 1);
            chk($sformatf("t6_bp_addr_%0d", c), mem_req_addr, 32'hC0C0);
            chk($sformatf("t6_bp_tag_%0d", c), mem_req_tag, 0);
            tick();
            chk($sformatf("t6_bp_cnt_%0d", c), outstanding_cnt, 0);
        end
        mem_req_ready = 1'b1;
        #1;
        chk("t6_gnt", ld_req_gnt, 1);
        chk("t6_gnt_tag", mem_req_tag, 0);
        tick();
        ld_req_valid = 1'b0;
        chk("t6_cnt", outstanding_cnt, 1);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 2'd0;
        mem_rsp_data  = 32'hAA;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t6_ld_rsp_valid", ld_rsp_valid, 1);
        chk("t6_ld_rsp_data", ld_rsp_data, 32'hAA);
        chk("t6_cnt_end", outstanding_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_req_arb
`default_nettype wire

// File: doc/mem_req_arb.md
Name: mem_req_arb

Overview:
Shares the single fill-buffer/memory request port between the instruction fetch requester (FE) and the data-side miss requester (LD).
- Round-robin arbitration between the two requesters.
- Allocates a tag per outstanding request from a small pool and routes tagged responses back to the owner.
- Drops FE responses made stale by a branch-mispredict flush.
- Sits between fetch control / load miss logic and the fill buffer.

Parameters:
PADDR_W, 32, physical address width
DATA_W, 32, response data width
NUM_TAGS, 4, outstanding request slots (power of 2, >=2)
TAG_W, $clog2(NUM_TAGS), tag width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fe_req_valid  in  1  FE request; held stable until fe_req_gnt
fe_req_addr  in  PADDR_W  FE request address
fe_req_gnt  out  1  FE request accepted this cycle
ld_req_valid  in  1  LD request; held stable until ld_req_gnt
ld_req_addr  in  PADDR_W  LD request address
ld_req_gnt  out  1  LD request accepted this cycle
fe_flush  in  1  branch mispredict: discard all in-flight FE requests
mem_req_valid  out  1  downstream request valid
mem_req_addr  out  PADDR_W  downstream address
mem_req_tag  out  TAG_W  allocated tag
mem_req_ready  in  1  downstream accepts this cycle
mem_rsp_valid  in  1  downstream response valid
mem_rsp_tag  in  TAG_W  response tag
mem_rsp_data  in  DATA_W  response data
fe_rsp_valid  out  1  response to FE
fe_rsp_data  out  DATA_W  FE response data
ld_rsp_valid  out  1  response to LD
ld_rsp_data  out  DATA_W  LD response data
outstanding_cnt  out  TAG_W+1  number of allocated tags

Behaviour:
- Tag table: per tag `vld`, `src` (FE/LD) and `stale`.
  - Reset: all `vld`=0; `rr_last`=LD, so FE wins the first conflict.
  - All outputs 0 on reset.
- Eligibility:
  - FE eligible = fe_req_valid & ~fe_flush.
  - LD eligible = ld_req_valid.
- Selection:
  - If only one requester is eligible, it is selected.
  - If both are eligible, the one opposite `rr_last` is selected.
- Free tag: the lowest-index tag with `vld`=0. A tag freed by a response in cycle N is allocatable from cycle N+1, not in cycle N.
- mem_req_valid = any eligible & free tag exists. It is combinational and carries the selected requester's address plus the free tag.
- Grant (combinational, same cycle): the selected requester's gnt = mem_req_valid & mem_req_ready.
  - On grant, at the clock edge: tag `vld`=1, `src`=requester, `stale`=0, and `rr_last`=requester.
  - No grant means no state change. `rr_last` only updates on an actual grant.
- Full: all tags `vld` → mem_req_valid=0, both gnt=0. Requesters keep holding.
- fe_flush:
  - At the clock edge, sets `stale`=1 on every `vld` tag with `src`=FE.
  - Blocks FE grant in the same cycle.
  - LD traffic is unaffected.
- Response in cycle N:
  - Tag `vld` is cleared at the edge.
  - Outputs are registered, appearing in cycle N+1:
    - src=FE & ~stale → fe_rsp_valid=1 with the data.
    - src=LD → ld_rsp_valid=1 with the data.
    - stale → no output; the tag is still freed.
- Response and fe_flush in the same cycle for an FE tag: the response is dropped (flush wins).
- Response with a tag whose `vld`=0: ignored. Assertion fires under ASSERT.
- Response and grant in the same cycle: both take effect. The grant uses a different (already-free) tag.
- outstanding_cnt: registered popcount of `vld`, updated each edge.
- Reset mid-operation:
  - All tags are cleared and `rr_last` returns to its reset value.
  - Responses arriving after reset for pre-reset tags are ignored per the unallocated-tag rule.
- The rsp_data outputs hold their last value when rsp_valid=0.

Decomposition:
- Shared package mem_common:
  - t_mem_src enum {SRC_FE, SRC_LD}
  - t_mem_tag
  - t_mem_req struct {valid, addr, tag}
  - t_mem_rsp struct {valid, tag, data}
- One sub-module, mem_tag_tracker:
  - Holds the tag table.
  - Provides free-tag find-first, allocate, free and flush-mark.
  - Provides the popcount and the response lookup (src, stale).
- The arbiter and response routing stay in mem_req_arb.

Test Plan:
- Single FE req addr=0x100, ready=1 → fe_req_gnt=1 and mem_req_tag=0 in the same cycle. Rsp tag 0, data 0xDEADBEEF → fe_rsp_valid=1, data 0xDEADBEEF one cycle later; outstanding_cnt 1→0.
- FE and LD both valid every cycle after reset, ready=1 → grants alternate FE, LD, FE, LD; tags 0,1,2,3. 5th cycle: no grant (full), outstanding_cnt=4.
- Full pool, rsp tag 2 in cycle N → next grant in cycle N+1 uses tag 2, not earlier.
- FE tags 0,1 outstanding, fe_flush pulse, then rsp tags 0,1 → no fe_rsp_valid, outstanding_cnt=0. A new FE req after the flush gets a normal response.
- fe_flush in the same cycle as a pending FE req and as the rsp for FE tag 0 → fe_req_gnt=0 that cycle. Tag 0 is freed with no fe_rsp_valid. FE is granted the following cycle.
- mem_req_ready=0 for 3 cycles with LD valid → ld_req_gnt=0 and no tag allocated. Addr/tag stable on mem_req; grant on the 4th cycle when ready=1.
